// File: rtl/draw_pkg.sv
// Shared FSM state type, AXI encodings and address helper for the VRAM write master.
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITF = 3'd1,
    AWREQ = 3'd2,
    WBEAT = 3'd3,
    BRESP = 3'd4
  } draw_state_e;

  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] VRAM_TOP       = 3'b001;

  // Byte address of the next burst; wraps inside the 29-bit VRAM window.
  function automatic logic [28:0] next_burst_addr(input logic [28:0] addr,
                                                  input int unsigned burst_len);
    return addr + 29'(burst_len * 8);
  endfunction

endpackage

// File: rtl/draw_wfifo.sv
// Synchronous first-word-fall-through FIFO holding packed 64-bit pixel pairs.
module draw_wfifo
  import draw_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_s;
  logic          pop_s;

  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_o;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == (AW+1)'(0));
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_s && !pop_s) begin
        count_q <= count_q + (AW+1)'(1);
      end else if (pop_s && !push_s) begin
        count_q <= count_q - (AW+1)'(1);
      end else begin
        count_q <= count_q;
      end
    end
  end

endmodule

// File: rtl/draw_vramwr.sv
// AXI4 write master packing a 32-bit pixel stream into 64-bit INCR bursts for VRAM.
// Define DRAW_BRESP_CHECK_EN to add a sticky ERR output for non-OKAY write responses.
module draw_vramwr
  import draw_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN          = 16,
  parameter int FIFO_DEPTH         = 32
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            START,
  input  logic [28:0]                     BASEADDR,
  input  logic [15:0]                     NWORDS,
  input  logic [31:0]                     PIX_DATA,
  input  logic                            PIX_VALID,
  output logic                            PIX_READY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic                            BUSY,
`ifdef DRAW_BRESP_CHECK_EN
  output logic                            ERR,
`endif
  output logic                            DONE
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  draw_state_e   state_q;
  logic [28:0]   addr_q;
  logic [15:0]   nwords_q;
  logic [15:0]   remaining_q;
  logic [15:0]   packed_q;
  logic          half_q;
  logic [31:0]   lo_pix_q;
  logic [BW-1:0] beat_q;
  logic          busy_q;
  logic          done_q;
  logic          awvalid_q;
  logic          wvalid_q;
  logic          wlast_q;
  logic          bready_q;

  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic [CW-1:0]                 fifo_count_s;
  logic [C_M_AXI_DATA_WIDTH-1:0] fifo_head_s;
  logic                          start_fire_s;
  logic                          pix_fire_s;
  logic                          push_s;
  logic                          pop_s;
  logic                          b_fire_s;

  assign start_fire_s = START & (state_q == IDLE);
  assign PIX_READY    = busy_q & ~fifo_full_s & (packed_q < nwords_q);
  assign pix_fire_s   = PIX_VALID & PIX_READY;
  assign push_s       = pix_fire_s & half_q;
  assign pop_s        = wvalid_q & M_AXI_WREADY & ~fifo_empty_s;
  assign b_fire_s     = bready_q & M_AXI_BVALID;

  draw_wfifo #(
    .DW    (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_wfifo (
    .clk_i   (ACLK),
    .rst_ni  (ARESETN),
    .push_i  (push_s),
    .data_i  ({PIX_DATA, lo_pix_q}),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Address and data are forced to zero outside their valid phases so reset shows all-zero outputs.
  assign M_AXI_AWADDR  = awvalid_q ? C_M_AXI_ADDR_WIDTH'({VRAM_TOP, addr_q})
                                   : {C_M_AXI_ADDR_WIDTH{1'b0}};
  assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_AWSIZE  = AXI_SIZE_8B;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = fifo_head_s & {C_M_AXI_DATA_WIDTH{wvalid_q}};
  assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;

  // Pixel pairing: the low half is held until its partner arrives and the pair is pushed together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      half_q   <= 1'b0;
      packed_q <= 16'd0;
      lo_pix_q <= 32'd0;
    end else if (start_fire_s) begin
      half_q   <= 1'b0;
      packed_q <= 16'd0;
    end else if (pix_fire_s) begin
      if (half_q) begin
        half_q   <= 1'b0;
        packed_q <= packed_q + 16'd1;
      end else begin
        half_q   <= 1'b1;
        lo_pix_q <= PIX_DATA;
      end
    end
  end

  // Burst sequencer: a burst is only requested once a full burst of data is already buffered.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      addr_q      <= 29'd0;
      nwords_q    <= 16'd0;
      remaining_q <= 16'd0;
      beat_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            addr_q      <= BASEADDR;
            nwords_q    <= NWORDS;
            remaining_q <= NWORDS;
            busy_q      <= 1'b1;
            state_q     <= WAITF;
          end
        end
        WAITF: begin
          if (fifo_count_s >= CW'(BURST_LEN)) begin
            awvalid_q <= 1'b1;
            state_q   <= AWREQ;
          end
        end
        AWREQ: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            wlast_q   <= (BURST_LEN == 1);
            state_q   <= WBEAT;
          end
        end
        WBEAT: begin
          if (M_AXI_WREADY) begin
            if (beat_q == BW'(BURST_LEN - 1)) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= BRESP;
            end else begin
              beat_q  <= beat_q + BW'(1);
              wlast_q <= (beat_q == BW'(BURST_LEN - 2));
            end
          end
        end
        BRESP: begin
          if (M_AXI_BVALID) begin
            bready_q    <= 1'b0;
            addr_q      <= next_burst_addr(addr_q, BURST_LEN);
            remaining_q <= remaining_q - 16'(BURST_LEN);
            if (remaining_q == 16'(BURST_LEN)) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              state_q <= WAITF;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef DRAW_BRESP_CHECK_EN
  logic err_q;

  // Sticky response error, cleared only when a new transfer is accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      err_q <= 1'b0;
    end else if (start_fire_s) begin
      err_q <= 1'b0;
    end else if (b_fire_s && (M_AXI_BRESP != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign ERR = err_q;
`else
  logic unused_bresp_s;
  assign unused_bresp_s = (^M_AXI_BRESP) & b_fire_s;
`endif

endmodule

// File: tb/tb_draw_vramwr.sv
`timescale 1ns/1ps
module tb_draw_vramwr;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        START = 1'b0;
  logic [28:0] BASEADDR = 29'd0;
  logic [15:0] NWORDS = 16'd0;
  logic [31:0] PIX_DATA = 32'd0;
  logic        PIX_VALID = 1'b0;
  logic        PIX_READY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY = 1'b0;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY = 1'b0;
  logic [1:0]  BRESP = 2'b00;
  logic        BVALID = 1'b0;
  logic        BREADY;
  logic        BUSY;
  logic        DONE;
`ifdef DRAW_BRESP_CHECK_EN
  logic        ERR;
`endif

  draw_vramwr dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .BASEADDR(BASEADDR), .NWORDS(NWORDS),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
    .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .BUSY(BUSY),
`ifdef DRAW_BRESP_CHECK_EN
    .ERR(ERR),
`endif
    .DONE(DONE)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [28:0] base;
    logic [15:0] nwords;
    bit          gaps;
    bit          stall;
    bit          restart;
    int          err_burst;
    int          exp_bursts;
    logic [31:0] exp_last_aw;
    logic [63:0] exp_first;
    bit          exp_err;
  } vec_t;
  vec_t vecs[7];

  logic [63:0] sb_q[$];
  logic [31:0] exp_aw_q[$];
  int aw_cnt = 0, open_b = 0, wbeat = 0, w_total = 0, b_pend = 0, b_idx = 0, done_cnt = 0;
  int err_burst = -1;
  bit stall_en = 1'b0;
  logic [31:0] last_aw = 32'd0;
  logic [63:0] first_w = 64'd0;
  bit first_w_seen = 1'b0;
  bit prev_aw_wait = 1'b0, prev_w_wait = 1'b0;
  logic [31:0] prev_awaddr = 32'd0;
  logic [63:0] prev_wdata = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int v, input int i);
    if (v == 0) return 32'(i + 1);
    return (32'(i) * 32'h9E3779B1) ^ 32'(v << 24);
  endfunction

  // AXI slave: ready randomisation and B responses for completed bursts
  always @(posedge ACLK) begin
    #1;
    AWREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    WREADY  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    BVALID  = (b_pend > 0) && (!stall_en || ($urandom_range(0, 1) == 1));
    BRESP   = (b_idx == err_burst) ? 2'b10 : 2'b00;
  end

  // Monitor: handshakes are evaluated on the falling edge with stable inputs
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_aw_wait = 1'b0;
      prev_w_wait  = 1'b0;
    end else begin
      if (prev_aw_wait) begin
        chk("aw_hold_valid", AWVALID, 1);
        chk("aw_hold_addr", AWADDR, prev_awaddr);
      end
      if (prev_w_wait) begin
        chk("w_hold_valid", WVALID, 1);
        chk("w_hold_data", WDATA, prev_wdata);
      end
      if (AWVALID && AWREADY) begin
        chk("aw_after_b", open_b, 0);
        chk("aw_expected", exp_aw_q.size() != 0, 1);
        if (exp_aw_q.size() != 0) chk("awaddr", AWADDR, exp_aw_q.pop_front());
        chk("awlen", AWLEN, 15);
        chk("awsize", AWSIZE, 3);
        chk("awburst", AWBURST, 1);
        aw_cnt++;
        last_aw = AWADDR;
        open_b++;
        wbeat = 0;
      end
      prev_aw_wait = AWVALID && !AWREADY;
      prev_awaddr  = AWADDR;
      if (WVALID && WREADY) begin
        chk("w_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) chk("wdata", WDATA, sb_q.pop_front());
        chk("wlast", WLAST, wbeat == 15);
        chk("wstrb", WSTRB, 8'hFF);
        if (!first_w_seen) begin
          first_w = WDATA;
          first_w_seen = 1'b1;
        end
        if (wbeat == 15) b_pend++;
        wbeat++;
        w_total++;
      end
      prev_w_wait = WVALID && !WREADY;
      prev_wdata  = WDATA;
      if (BVALID && BREADY) begin
        open_b--;
        if (b_pend > 0) b_pend--;
        b_idx++;
      end
      if (DONE) done_cnt++;
    end
  end

  task automatic feed(input int vi, input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    logic [31:0] lo = 32'd0;
    while (i < n && guard < 20000) begin
      @(negedge ACLK);
      if (PIX_VALID && PIX_READY) begin
        if (i % 2 == 0) lo = PIX_DATA;
        else sb_q.push_back({PIX_DATA, lo});
        i++;
      end
      @(posedge ACLK); #1;
      if (i < n) begin
        PIX_VALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        PIX_DATA  = pix(vi, i);
      end else begin
        PIX_VALID = 1'b0;
      end
      guard++;
    end
    chk("feed_complete", i, n);
    PIX_VALID = 1'b0;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int lat = 0;
    int guard = 0;
    v = vecs[vi];
    aw_cnt = 0; done_cnt = 0; first_w_seen = 1'b0; b_idx = 0;
    err_burst = v.err_burst;
    stall_en = v.stall;
    for (int b = 0; b < int'(v.nwords) / 16; b++)
      exp_aw_q.push_back({3'b001, v.base + 29'(b * 128)});
    @(posedge ACLK); #1;
    START = 1'b1; BASEADDR = v.base; NWORDS = v.nwords;
    @(posedge ACLK); #1;
    START = 1'b0; BASEADDR = 29'd0; NWORDS = 16'd0;
    chk("busy_after_start", BUSY, 1);
`ifdef DRAW_BRESP_CHECK_EN
    chk("err_cleared_by_start", ERR, 0);
`endif
    fork
      feed(vi, 2 * int'(v.nwords), v.gaps);
      begin
        while (!AWVALID && lat < 4000) begin
          @(negedge ACLK);
          lat++;
        end
      end
      begin
        if (v.restart) begin
          repeat (8) @(posedge ACLK);
          #2; START = 1'b1; BASEADDR = 29'h0007F80; NWORDS = 16'd32;
          @(posedge ACLK); #2; START = 1'b0;
        end
      end
    join
    chk("start_to_aw_latency_ok", lat >= 34, 1);
    while (done_cnt == 0 && guard < 20000) begin
      @(negedge ACLK);
      guard++;
    end
    chk("done_in_time", guard < 20000, 1);
    repeat (3) @(negedge ACLK);
    chk("done_pulses", done_cnt, 1);
    chk("aw_count", aw_cnt, v.exp_bursts);
    chk("last_awaddr", last_aw, v.exp_last_aw);
    chk("first_wdata", first_w, v.exp_first);
    chk("words_left", sb_q.size(), 0);
    chk("aw_left", exp_aw_q.size(), 0);
    chk("busy_end", BUSY, 0);
    chk("pix_ready_end", PIX_READY, 0);
`ifdef DRAW_BRESP_CHECK_EN
    chk("err_end", ERR, v.exp_err);
`endif
    sb_q.delete();
    exp_aw_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int guard;
    vecs[0] = '{29'h0000080, 16'd16, 1'b0, 1'b0, 1'b0, -1, 1, 32'h20000080, 64'h0000000200000001, 1'b0};
    vecs[1] = '{29'h0000000, 16'd48, 1'b0, 1'b0, 1'b0, -1, 3, 32'h20000100, {pix(1, 1), pix(1, 0)}, 1'b0};
    vecs[2] = '{29'h1FFFFF80, 16'd32, 1'b1, 1'b1, 1'b0, -1, 2, 32'h20000000, {pix(2, 1), pix(2, 0)}, 1'b0};
    vecs[3] = '{29'h0001000, 16'd64, 1'b1, 1'b1, 1'b0, -1, 4, 32'h20001180, {pix(3, 1), pix(3, 0)}, 1'b0};
    vecs[4] = '{29'h0000100, 16'd16, 1'b0, 1'b0, 1'b1, -1, 1, 32'h20000100, {pix(4, 1), pix(4, 0)}, 1'b0};
    vecs[5] = '{29'h0002000, 16'd32, 1'b0, 1'b1, 1'b0, 0, 2, 32'h20002080, {pix(5, 1), pix(5, 0)}, 1'b1};
    vecs[6] = '{29'h0003000, 16'd16, 1'b0, 1'b0, 1'b0, -1, 1, 32'h20003000, {pix(6, 1), pix(6, 0)}, 1'b0};

    repeat (3) @(negedge ACLK);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_awaddr", AWADDR, 0);
    chk("rst_awlen", AWLEN, 15);
    chk("rst_awsize", AWSIZE, 3);
    chk("rst_awburst", AWBURST, 1);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wdata", WDATA, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_wstrb", WSTRB, 8'hFF);
    chk("rst_bready", BREADY, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_pix_ready", PIX_READY, 0);
`ifdef DRAW_BRESP_CHECK_EN
    chk("rst_err", ERR, 0);
`endif
    @(posedge ACLK); #1;
    ARESETN = 1'b1;

    for (int k = 0; k < 7; k++) run_vec(k);

    // Reset in the middle of a write burst
    stall_en = 1'b0; err_burst = -1;
    exp_aw_q.push_back(32'h20000000);
    @(posedge ACLK); #1;
    START = 1'b1; BASEADDR = 29'd0; NWORDS = 16'd16;
    @(posedge ACLK); #1;
    START = 1'b0;
    w0 = w_total;
    feed(0, 32, 1'b0);
    guard = 0;
    while (w_total - w0 < 5 && guard < 500) begin
      @(negedge ACLK);
      guard++;
    end
    chk("reset_seq_reached_wbeat", guard < 500, 1);
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("midrst_wvalid", WVALID, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_awvalid", AWVALID, 0);
    chk("midrst_bready", BREADY, 0);
    chk("midrst_pix_ready", PIX_READY, 0);
    sb_q.delete();
    exp_aw_q.delete();
    open_b = 0;
    b_pend = 0;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
